branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 39 +++
 rtl/branch_resolver_compare.sv | 27 ++
 rtl/branch_resolver.sv | 118 +++++++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: branch-type encodings,
// 2-bit predictor counter states and the default datapath width.
package branch_resolver_pkg;

   localparam int BUS_WIDTH = 32;

   typedef enum logic [2:0] {
      BR_BEQ    = 3'd0,
      BR_BNE    = 3'd1,
      BR_NEVER  = 3'd2,
      BR_ALWAYS = 3'd3,
      BR_BLT    = 3'd4,
      BR_BGE    = 3'd5,
      BR_BLTU   = 3'd6,
      BR_BGEU   = 3'd7
   } br_type_e;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   function automatic logic is_conditional(input logic [2:0] t);
      return !((t == BR_NEVER) || (t == BR_ALWAYS));
   endfunction

   // Saturating up/down step of a 2-bit predictor counter.
   function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
      logic [1:0] r;
      r = c;
      if (taken && (c != CTR_STRONG_T)) begin
         r = c + 2'd1;
      end else if (!taken && (c != CTR_STRONG_NT)) begin
         r = c - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_resolver_compare.sv
// Pure combinational branch comparator: decides taken from type and operands.
module branch_compare #(
   parameter int BUS_WIDTH = branch_resolver_pkg::BUS_WIDTH
) (
   input  logic [2:0]           br_type_i,
   input  logic [BUS_WIDTH-1:0] a_i,
   input  logic [BUS_WIDTH-1:0] b_i,
   output logic                 taken_o
);
   import branch_resolver_pkg::*;

   always_comb begin
      taken_o = 1'b0;
      case (br_type_e'(br_type_i))
         BR_BEQ:    taken_o = (a_i == b_i);
         BR_BNE:    taken_o = (a_i != b_i);
         BR_NEVER:  taken_o = 1'b0;
         BR_ALWAYS: taken_o = 1'b1;
         BR_BLT:    taken_o = ($signed(a_i) <  $signed(b_i));
         BR_BGE:    taken_o = ($signed(a_i) >= $signed(b_i));
         BR_BLTU:   taken_o = (a_i <  b_i);
         BR_BGEU:   taken_o = (a_i >= b_i);
         default:   taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: resolves branches through a single-entry output register,
// trains a 2-bit bimodal BHT and keeps saturating branch/mispredict counters.
module branch_resolver #(
   parameter int BUS_WIDTH = branch_resolver_pkg::BUS_WIDTH,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] lu_pc,
   output logic                 lu_pred_taken,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           br_type,
   input  logic [BUS_WIDTH-1:0] A,
   input  logic [BUS_WIDTH-1:0] B,
   input  logic [BUS_WIDTH-1:0] pc,
   input  logic                 pred_taken,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 br_taken,
   output logic                 mispredict,
   input  logic                 flush,
   output logic [CNT_WIDTH-1:0] br_cnt,
   output logic [CNT_WIDTH-1:0] miss_cnt
);
   import branch_resolver_pkg::*;

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]           bht_q [BHT_DEPTH];
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     lu_idx;
   logic                 taken;
   logic                 accept;
   logic                 cond;
   logic                 out_valid_q, out_valid_d;
   logic                 br_taken_q, br_taken_d;
   logic                 mispredict_q, mispredict_d;
   logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
   logic                 unused_pc_bits;

   assign idx    = pc[IDX_W+1:2];
   assign lu_idx = lu_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pc[BUS_WIDTH-1:IDX_W+2], pc[1:0],
                             lu_pc[BUS_WIDTH-1:IDX_W+2], lu_pc[1:0]};

   branch_compare #(.BUS_WIDTH(BUS_WIDTH)) u_compare (
      .br_type_i (br_type),
      .a_i       (A),
      .b_i       (B),
      .taken_o   (taken)
   );

   // Gating with rst_n keeps the request side closed while reset is held.
   assign in_ready      = rst_n && !flush && (!out_valid_q || out_ready);
   assign accept        = in_valid && in_ready;
   assign cond          = is_conditional(br_type);
   assign lu_pred_taken = bht_q[lu_idx][1];

   assign out_valid  = out_valid_q;
   assign br_taken   = br_taken_q;
   assign mispredict = mispredict_q;
   assign br_cnt     = br_cnt_q;
   assign miss_cnt   = miss_cnt_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      br_taken_d   = br_taken_q;
      mispredict_d = mispredict_q;
      br_cnt_d     = br_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d  = 1'b1;
         br_taken_d   = taken;
         mispredict_d = (taken != pred_taken);
         if (cond && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
         end
         if (cond && (taken != pred_taken) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         br_taken_q   <= 1'b0;
         mispredict_q <= 1'b0;
         br_cnt_q     <= '0;
         miss_cnt_q   <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         br_taken_q   <= br_taken_d;
         mispredict_q <= mispredict_d;
         br_cnt_q     <= br_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Only conditional branches train the predictor; accept already excludes flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= CTR_WEAK_NT;
         end
      end else if (accept && cond) begin
         bht_q[idx] <= ctr_update(bht_q[idx], taken);
      end
   end

endmodule
